// File: rtl/ov7670_sccb_arbiter_if.sv
// ----------------------------------------------------------------------------
// ov7670_sccb_arbiter_if
//   Bundles the requester-side and SCCB-master-side signals of the OV7670
//   SCCB write arbiter.
//
//   Modports
//     slave  : the arbiter itself. It takes requests and master status, and
//              drives grants, completions and the master command.
//     master : the environment around the arbiter, that is the requesters and
//              the SCCB write master.
//
//   Signals
//     req_valid   [NUM_REQ]    level per requester, held until its req_done
//     req_addr    [8*NUM_REQ]  register address, requester i at [8i+7:8i]
//     req_data    [8*NUM_REQ]  register data, same packing
//     req_grant   [NUM_REQ]    one-hot, high while requester owns the master
//     req_done    [NUM_REQ]    1-cycle pulse at end of a requester transaction
//     req_nack                 qualifies req_done: final attempt failed
//     sccb_addr/sccb_data [8]  command to the SCCB master
//     sccb_en                  start request to the SCCB master
//     sccb_ready               master idle
//     sccb_busy                master transaction in progress
//     sccb_ack                 slave ack result, valid when busy falls
//     err_timeout              sticky timeout flag
// ----------------------------------------------------------------------------
interface ov7670_sccb_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_grant;
    logic [NUM_REQ-1:0]   req_done;
    logic                 req_nack;
    logic [7:0]           sccb_addr;
    logic [7:0]           sccb_data;
    logic                 sccb_en;
    logic                 sccb_ready;
    logic                 sccb_busy;
    logic                 sccb_ack;
    logic                 err_timeout;

    modport slave (
        input  req_valid, req_addr, req_data, sccb_ready, sccb_busy, sccb_ack,
        output req_grant, req_done, req_nack, sccb_addr, sccb_data, sccb_en,
               err_timeout
    );

    modport master (
        output req_valid, req_addr, req_data, sccb_ready, sccb_busy, sccb_ack,
        input  req_grant, req_done, req_nack, sccb_addr, sccb_data, sccb_en,
               err_timeout
    );
endinterface

// File: rtl/ov7670_sccb_arbiter.sv
// ----------------------------------------------------------------------------
// ov7670_sccb_arbiter
//   Shares one OV7670 SCCB write master between NUM_REQ register-write
//   requesters. The arbiter grants round-robin and runs one 3-phase write per
//   grant. It returns a done pulse per requester, plus a shared nack flag.
//   Everything runs on the SCCB state clock.
//
//   Ports
//     clk_800KHz  SCCB state clock
//     rst         asynchronous, active-high reset (aborts any transaction)
//     bus         ov7670_sccb_arbiter_if.slave (requesters + SCCB master)
//
//   Parameters
//     NUM_REQ      number of requesters (1..8)
//     TIMEOUT_CYC  cycle limit for busy to rise after sccb_en, or to fall
//     GAP_CYC      idle cycles forced after every attempt (>= 1)
//     MAX_RETRY    re-issues after a NACK (SCCB_RETRY_EN builds only)
//
//   Build option
//     SCCB_RETRY_EN  when defined, a NACKed write is re-issued up to
//                    MAX_RETRY times before it is reported. Timeouts are
//                    never retried.
// ----------------------------------------------------------------------------
module ov7670_sccb_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 64,
    parameter int GAP_CYC     = 4,
    parameter int MAX_RETRY   = 2
) (
    input  logic                  clk_800KHz,
    input  logic                  rst,
    ov7670_sccb_arbiter_if.slave  bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   NREQ_V   = (IDX_W + 1)'(NUM_REQ);

`ifdef SCCB_RETRY_EN
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
`endif

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP,
        GAP
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] pick_idx;
    logic [TMR_W-1:0] timer;
    logic [GAP_W-1:0] gap_cnt;
    logic             nack_r;

`ifdef SCCB_RETRY_EN
    logic [RTY_W-1:0] retry_cnt;
    logic             retry_pend;
`endif

    // First valid requester at or after start, wrapping at NUM_REQ-1.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] valid,
        input logic [IDX_W-1:0]   start
    );
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] sel;
        logic             found;
        sel   = start;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, start} + (IDX_W + 1)'(i);
            if (sum >= NREQ_V) begin
                sum = sum - NREQ_V;
            end
            if (!found && valid[sum[IDX_W-1:0]]) begin
                sel   = sum[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick_idx = rr_pick(bus.req_valid, rr_ptr);

    always_ff @(posedge clk_800KHz or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            gnt_idx         <= '0;
            timer           <= '0;
            gap_cnt         <= '0;
            nack_r          <= 1'b0;
            bus.req_grant   <= '0;
            bus.req_done    <= '0;
            bus.req_nack    <= 1'b0;
            bus.sccb_addr   <= '0;
            bus.sccb_data   <= '0;
            bus.sccb_en     <= 1'b0;
            bus.err_timeout <= 1'b0;
`ifdef SCCB_RETRY_EN
            retry_cnt       <= '0;
            retry_pend      <= 1'b0;
`endif
        end else begin
            // Completion outputs are single-cycle pulses.
            bus.req_done <= '0;
            bus.req_nack <= 1'b0;

            case (state)
                IDLE: begin
                    if ((|bus.req_valid) && bus.sccb_ready) begin
                        gnt_idx       <= pick_idx;
                        bus.req_grant <= NUM_REQ'(1) << pick_idx;
                        bus.sccb_addr <= bus.req_addr[{pick_idx, 3'b000} +: 8];
                        bus.sccb_data <= bus.req_data[{pick_idx, 3'b000} +: 8];
                        state         <= ISSUE;
                    end
                end

                ISSUE: begin
                    bus.sccb_en <= 1'b1;
                    timer       <= '0;
                    state       <= WAIT_BUSY;
                end

                WAIT_BUSY: begin
                    if (bus.sccb_busy) begin
                        bus.sccb_en <= 1'b0;
                        timer       <= '0;
                        state       <= WAIT_DONE;
                    end else if (timer == TMR_LAST) begin
                        bus.sccb_en     <= 1'b0;
                        bus.err_timeout <= 1'b1;
                        nack_r          <= 1'b1;
                        state           <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                WAIT_DONE: begin
                    if (!bus.sccb_busy && bus.sccb_ready) begin
`ifdef SCCB_RETRY_EN
                        // A NACK with retries left goes back round through
                        // GAP, keeping the grant and the latched command.
                        if (!bus.sccb_ack && (retry_cnt < RTY_MAX)) begin
                            retry_cnt  <= retry_cnt + 1'b1;
                            retry_pend <= 1'b1;
                            gap_cnt    <= '0;
                            state      <= GAP;
                        end else begin
                            nack_r <= ~bus.sccb_ack;
                            state  <= RESP;
                        end
`else
                        nack_r <= ~bus.sccb_ack;
                        state  <= RESP;
`endif
                    end else if (timer == TMR_LAST) begin
                        bus.err_timeout <= 1'b1;
                        nack_r          <= 1'b1;
                        state           <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                RESP: begin
                    bus.req_done  <= bus.req_grant;
                    bus.req_nack  <= nack_r;
                    bus.req_grant <= '0;
                    nack_r        <= 1'b0;
                    // The requester just served drops to lowest priority.
                    rr_ptr        <= (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
                    gap_cnt       <= '0;
`ifdef SCCB_RETRY_EN
                    retry_cnt     <= '0;
`endif
                    state         <= GAP;
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
`ifdef SCCB_RETRY_EN
                        retry_pend <= 1'b0;
                        state      <= retry_pend ? ISSUE : IDLE;
`else
                        state      <= IDLE;
`endif
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_sccb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ov7670_sccb_arbiter
//   Scoreboard bench for ov7670_sccb_arbiter. A behavioural SCCB master model
//   answers sccb_en. The expected grants and completions are queued when
//   requests are posted. They are checked when sccb_en rises and when req_done
//   pulses.
// ----------------------------------------------------------------------------
module tb_ov7670_sccb_arbiter;

    localparam int NUM_REQ     = 2;
    localparam int TIMEOUT_CYC = 64;
    localparam int GAP_CYC     = 4;
    localparam int MAX_RETRY   = 2;
`ifdef SCCB_RETRY_EN
    localparam int EXP_EN_NACK = 1 + MAX_RETRY;
`else
    localparam int EXP_EN_NACK = 1;
`endif

    logic clk_800KHz = 1'b0;
    logic rst        = 1'b1;

    always #625 clk_800KHz = ~clk_800KHz;

    ov7670_sccb_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    ov7670_sccb_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .GAP_CYC    (GAP_CYC),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .clk_800KHz(clk_800KHz),
        .rst       (rst),
        .bus       (bus)
    );

    typedef struct {
        int         idx;
        logic [7:0] addr;
        logic [7:0] data;
        logic       nack;
    } exp_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } rq_t;

    exp_t sb_q[$];
    rq_t  rq0[$];
    rq_t  rq1[$];

    int n_cmp = 0;
    int n_err = 0;

    // SCCB master model controls
    logic ack_mode = 1'b1;
    logic no_busy  = 1'b0;
    int   busy_len = 4;

    // Monitor state
    int   cyc        = 0;
    int   en_count   = 0;
    int   en_start   = 0;
    int   en_len     = 0;
    int   gnt_rise   = 0;
    int   last_fall  = -1;
    logic first_en   = 1'b0;
    logic en_q       = 1'b0;
    logic busy_q     = 1'b0;
    logic [NUM_REQ-1:0] grant_q = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // SCCB master model: busy for busy_len cycles after sccb_en, then reports ack_mode.
    initial begin
        int m_cnt;
        m_cnt          = 0;
        bus.sccb_busy  = 1'b0;
        bus.sccb_ready = 1'b1;
        bus.sccb_ack   = 1'b0;
        forever begin
            @(negedge clk_800KHz);
            if (rst) begin
                m_cnt          = 0;
                bus.sccb_busy  = 1'b0;
                bus.sccb_ready = 1'b1;
                bus.sccb_ack   = 1'b0;
            end else if (m_cnt != 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    bus.sccb_busy  = 1'b0;
                    bus.sccb_ready = 1'b1;
                    bus.sccb_ack   = ack_mode;
                end
            end else if (bus.sccb_en && !no_busy) begin
                bus.sccb_busy  = 1'b1;
                bus.sccb_ready = 1'b0;
                bus.sccb_ack   = 1'b0;
                m_cnt          = busy_len;
            end
        end
    end

    task automatic apply(input int i);
        rq_t r;
        if (i == 0) begin
            if (rq0.size() == 0) begin bus.req_valid[0] = 1'b0; return; end
            r = rq0[0];
            bus.req_addr[7:0] = r.addr;
            bus.req_data[7:0] = r.data;
            bus.req_valid[0]  = 1'b1;
        end else begin
            if (rq1.size() == 0) begin bus.req_valid[1] = 1'b0; return; end
            r = rq1[0];
            bus.req_addr[15:8] = r.addr;
            bus.req_data[15:8] = r.data;
            bus.req_valid[1]   = 1'b1;
        end
    endtask

    task automatic post(input int i, input logic [7:0] a, input logic [7:0] d, input logic nk);
        exp_t e;
        rq_t  r;
        e.idx = i; e.addr = a; e.data = d; e.nack = nk;
        r.addr = a; r.data = d;
        sb_q.push_back(e);
        if (i == 0) rq0.push_back(r); else rq1.push_back(r);
    endtask

    task automatic advance(input int i);
        if (i == 0) begin
            if (rq0.size() != 0) void'(rq0.pop_front());
        end else begin
            if (rq1.size() != 0) void'(rq1.pop_front());
        end
        apply(i);
    endtask

    task automatic clear_mon();
        en_q      = 1'b0;
        busy_q    = 1'b0;
        grant_q   = '0;
        last_fall = -1;
        first_en  = 1'b0;
    endtask

    // One clock: sample #1 after the edge and run every per-cycle check.
    task automatic tick();
        exp_t e;
        @(posedge clk_800KHz);
        #1;
        cyc++;
        check("grant_onehot", 32'($countones(bus.req_grant) <= 1), 32'd1);
        if (bus.req_grant != '0 && grant_q == '0) begin
            gnt_rise = cyc;
            first_en = 1'b1;
        end
        if (bus.sccb_en && !en_q) begin
            en_count++;
            en_start = cyc;
            if (sb_q.size() == 0) begin
                check("en_unexpected", 32'd1, 32'd0);
            end else begin
                check("en_grant", 32'(bus.req_grant), 32'd1 << sb_q[0].idx);
                check("en_addr", 32'(bus.sccb_addr), 32'(sb_q[0].addr));
                check("en_data", 32'(bus.sccb_data), 32'(sb_q[0].data));
                if (first_en) check("gnt_to_en", 32'(cyc - gnt_rise), 32'd1);
                if (last_fall >= 0) check("gap_idle", 32'((cyc - last_fall) > GAP_CYC), 32'd1);
            end
            first_en = 1'b0;
        end
        if (!bus.sccb_en && en_q) en_len = cyc - en_start;
        if (!bus.sccb_busy && busy_q) begin
            last_fall = cyc;
            if (bus.req_grant != '0 && sb_q.size() != 0) begin
                check("addr_stable", 32'(bus.sccb_addr), 32'(sb_q[0].addr));
                check("data_stable", 32'(bus.sccb_data), 32'(sb_q[0].data));
            end
        end
        if (bus.req_done != '0) begin
            if (sb_q.size() == 0) begin
                check("done_unexpected", 32'(bus.req_done), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("done_idx", 32'(bus.req_done), 32'd1 << e.idx);
                check("done_nack", 32'(bus.req_nack), 32'(e.nack));
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_done[i]) advance(i);
            end
        end
        en_q    = bus.sccb_en;
        busy_q  = bus.sccb_busy;
        grant_q = bus.req_grant;
    endtask

    task automatic wait_all(input int budget);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || bus.req_valid != '0) && n < budget) begin
            tick();
            n++;
        end
        check("wait_budget", 32'(n < budget), 32'd1);
        if (n >= budget) begin
            sb_q.delete(); rq0.delete(); rq1.delete();
            bus.req_valid = '0;
        end
        repeat (2) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        repeat (2) @(posedge clk_800KHz);
        @(negedge clk_800KHz);
        rst = 1'b0;
        clear_mon();
    endtask

    initial begin
        int e0;
        int n;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;

        // Reset values while rst is held
        repeat (2) @(posedge clk_800KHz);
        #1;
        check("rst_grant", 32'(bus.req_grant), 32'd0);
        check("rst_done", 32'(bus.req_done), 32'd0);
        check("rst_nack", 32'(bus.req_nack), 32'd0);
        check("rst_en", 32'(bus.sccb_en), 32'd0);
        check("rst_addr", 32'(bus.sccb_addr), 32'd0);
        check("rst_data", 32'(bus.sccb_data), 32'd0);
        check("rst_err", 32'(bus.err_timeout), 32'd0);
        @(negedge clk_800KHz);
        rst = 1'b0;
        clear_mon();

        // Single request, acked
        e0 = en_count;
        post(0, 8'h12, 8'h80, 1'b0);
        apply(0);
        wait_all(200);
        check("single_en_cnt", 32'(en_count - e0), 32'd1);

        // Contention from a fresh pointer: 0,1,0,1
        do_reset();
        post(0, 8'h20, 8'h01, 1'b0);
        post(1, 8'h30, 8'h11, 1'b0);
        post(0, 8'h21, 8'h02, 1'b0);
        post(1, 8'h31, 8'h12, 1'b0);
        apply(0);
        apply(1);
        wait_all(400);

        // NACK on requester 1
        ack_mode = 1'b0;
        e0 = en_count;
        post(1, 8'h40, 8'h55, 1'b1);
        apply(1);
        wait_all(300);
        check("nack_en_cnt", 32'(en_count - e0), 32'(EXP_EN_NACK));
        ack_mode = 1'b1;

        // Timeout: busy never rises
        no_busy = 1'b1;
        e0 = en_count;
        check("pre_timeout_err", 32'(bus.err_timeout), 32'd0);
        post(0, 8'h0A, 8'h0B, 1'b1);
        apply(0);
        wait_all(300);
        check("timeout_err", 32'(bus.err_timeout), 32'd1);
        check("timeout_en_len", 32'(en_len), 32'(TIMEOUT_CYC));
        check("timeout_en_cnt", 32'(en_count - e0), 32'd1);
        no_busy = 1'b0;

        // Normal write afterwards; error flag is sticky
        post(0, 8'h0C, 8'h0D, 1'b0);
        apply(0);
        wait_all(200);
        check("err_sticky", 32'(bus.err_timeout), 32'd1);

        // Reset during WAIT_DONE on requester 1
        busy_len = 20;
        post(1, 8'h50, 8'h60, 1'b0);
        apply(1);
        n = 0;
        while (!(bus.sccb_busy && !bus.sccb_en && bus.req_grant != '0) && n < 50) begin
            tick();
            n++;
        end
        check("reach_wait_done", 32'(n < 50), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_grant", 32'(bus.req_grant), 32'd0);
        check("mid_rst_en", 32'(bus.sccb_en), 32'd0);
        check("mid_rst_addr", 32'(bus.sccb_addr), 32'd0);
        check("mid_rst_data", 32'(bus.sccb_data), 32'd0);
        check("mid_rst_done", 32'(bus.req_done), 32'd0);
        check("mid_rst_err", 32'(bus.err_timeout), 32'd0);
        sb_q.delete(); rq0.delete(); rq1.delete();
        bus.req_valid = '0;
        busy_len = 4;
        repeat (2) @(posedge clk_800KHz);
        @(negedge clk_800KHz);
        rst = 1'b0;
        clear_mon();

        // After reset the pointer restarts at requester 0
        post(0, 8'h70, 8'h71, 1'b0);
        post(1, 8'h72, 8'h73, 1'b0);
        apply(0);
        apply(1);
        wait_all(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
